// File: rtl/qk_inst_sequencer.sv
// qk_inst_sequencer
//   Emits the fullchip instruction word for one Q.K attention pass per start:
//   K load into the PE array, Q execute, ofifo drain wait, ofifo->pmem move.
// Ports
//   clk, reset    : rising-edge clock, async active-high reset
//   start         : one-cycle request, honoured only in IDLE
//   skip_load     : bypass K load and the load->execute gap (sampled with start)
//   num_q         : Q vectors to execute/move, clamped to MAX_Q (sampled with start)
//   q_base/p_base : first qkmem / pmem address (sampled with start)
//   ofifo_valid   : ofifo holds at least one result
//   inst          : {ofifo_rd, qkmem_add, pmem_add, execute, load, qmem_rd,
//                    qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}
//   busy, done    : run in progress / one-cycle completion pulse
// GAP and DRAIN are expected to be at least 1.
module qk_inst_sequencer #(
  parameter int COL    = 8,
  parameter int MAX_Q  = 16,
  parameter int ADDR_W = 4,
  parameter int GAP    = 10,
  parameter int DRAIN  = 10,
  localparam int INST_W = 9 + 2*ADDR_W,
  localparam int NQ_W   = $clog2(MAX_Q+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip_load,
  input  logic [NQ_W-1:0]   num_q,
  input  logic [ADDR_W-1:0] q_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam int M1      = (COL > GAP) ? COL : GAP;
  localparam int M2      = (DRAIN > MAX_Q) ? DRAIN : MAX_Q;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX+1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic [NQ_W-1:0]   nq;
    logic [ADDR_W-1:0] qb;
    logic [ADDR_W-1:0] pb;
  } cfg_t;

  typedef enum logic [3:0] {
    S_IDLE, S_KLOAD, S_KTAIL, S_GAP, S_EXEC, S_EXEND, S_DRAIN, S_MOVE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cfg_t              cfg_q, cfg_d;
  logic [ADDR_W-1:0] qk_q, qk_d, pa_q, pa_d;
  logic              ex_q, ex_d, ld_q, ld_d, qrd_q, qrd_d, krd_q, krd_d;
  logic              busy_q, done_q;
  logic [NQ_W-1:0]   nq_clamp;
  logic [CNT_W-1:0]  nq_last;
  logic              xfer;

  assign nq_clamp = (num_q > NQ_W'(MAX_Q)) ? NQ_W'(MAX_Q) : num_q;
  assign nq_last  = CNT_W'(cfg_q.nq) - CNT_ONE;

  // The move handshake is qualified by the live ofifo_valid so a read is
  // never issued against an empty fifo; everything else is a flop output.
  assign xfer = (state_q == S_MOVE) && ofifo_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    case (state_q)
      S_IDLE: if (start) begin
        cfg_d = '{nq: nq_clamp, qb: q_base, pb: p_base};
        cnt_d = '0;
        if (!skip_load)          state_d = S_KLOAD;
        else if (nq_clamp == '0) state_d = S_DONE;
        else                     state_d = S_EXEC;
      end
      S_KLOAD: if (cnt_q == CNT_W'(COL)) begin
        state_d = S_KTAIL; cnt_d = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      S_KTAIL: if (cnt_q == CNT_ONE) begin
        state_d = S_GAP; cnt_d = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      S_GAP: if (cnt_q == CNT_W'(GAP-1)) begin
        state_d = (cfg_q.nq == '0) ? S_DONE : S_EXEC; cnt_d = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      S_EXEC: if (cnt_q == nq_last) begin
        state_d = S_EXEND; cnt_d = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      S_EXEND: begin
        state_d = S_DRAIN; cnt_d = '0;
      end
      S_DRAIN: if (cnt_q == CNT_W'(DRAIN-1)) begin
        state_d = S_MOVE; cnt_d = '0;
      end else cnt_d = cnt_q + CNT_ONE;
      // Entry index only moves on a completed transfer; a stall holds pmem_add.
      S_MOVE: if (ofifo_valid) begin
        if (cnt_q == nq_last) begin
          state_d = S_DONE; cnt_d = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Word fields are decoded from the next state so they land with it.
  always_comb begin
    qk_d = '0; pa_d = '0; ex_d = 1'b0; ld_d = 1'b0; qrd_d = 1'b0; krd_d = 1'b0;
    case (state_d)
      S_KLOAD: begin
        ld_d = 1'b1;
        if (cnt_d != '0) begin
          krd_d = 1'b1;
          qk_d  = ADDR_W'(cnt_d - CNT_ONE);
        end
      end
      S_KTAIL: ld_d = (cnt_d == '0);
      S_EXEC: begin
        ex_d  = 1'b1;
        qrd_d = 1'b1;
        qk_d  = cfg_d.qb + ADDR_W'(cnt_d);
      end
      S_MOVE:  pa_d = cfg_d.pb + ADDR_W'(cnt_d);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      qk_q    <= '0;
      pa_q    <= '0;
      ex_q    <= 1'b0;
      ld_q    <= 1'b0;
      qrd_q   <= 1'b0;
      krd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      qk_q    <= qk_d;
      pa_q    <= pa_d;
      ex_q    <= ex_d;
      ld_q    <= ld_d;
      qrd_q   <= qrd_d;
      krd_q   <= krd_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign inst = {xfer, qk_q, pa_q, ex_q, ld_q, qrd_q, 1'b0, krd_q, 1'b0, 1'b0, xfer};
  assign busy = busy_q;
  assign done = done_q;

endmodule
